fp_uart_cmd_sequencer: RTL and testbench
========================================

# fp_uart_cmd_sequencer

Command sequencer between the UART byte link and the floating-point arithmetic unit. It assembles framed commands from the UART receiver: one opcode byte, then operand A and operand B, each 32 bits, MSB first. It issues each command to the FP unit over a valid/ready handshake, waits for the result, and streams a status byte plus the 32-bit result back through the single UART transmitter. It replaces ad-hoc per-state UART handling and is the only owner of the transmitter and the FP unit request port.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000000. Idle clocks allowed between bytes of a partially received frame.
- `TO_BITS`, default 20. Width of the timeout counter. Must satisfy 2^TO_BITS > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1. Clock.
- `reset`  in  1. Reset, asynchronous, active-high.
- `rx_valid`  in  1. One-cycle pulse: `rx_data` holds a received byte.
- `rx_data`  in  8. Received byte.
- `tx_start`  out  1. One-cycle pulse: transmitter begins sending `tx_data`.
- `tx_data`  out  8. Byte to transmit. Held stable from `tx_start` through `tx_done`.
- `tx_done`  in  1. One-cycle pulse: current byte fully sent.
- `op_valid`  out  1. FP request valid.
- `op_ready`  in  1. FP unit accepts the request.
- `op_code`  out  2. 0 = add, 1 = sub, 2 = mul.
- `op_a`  out  32. Operand A.
- `op_b`  out  32. Operand B.
- `res_valid`  in  1. One-cycle pulse: result available.
- `res_data`  in  32. Result.
- `res_err`  in  1. Qualified by `res_valid`: FP exception.
- `busy`  out  1. High in every state except IDLE.
- `done`  out  1. One-cycle pulse: response completed with ACK.
- `err`  out  1. One-cycle pulse: response completed with NAK.

## Operation
States: IDLE, RX_A, RX_B, ISSUE, WAIT_RES, TX_LOAD, TX_WAIT.

- **IDLE:**
  - On `rx_valid`, the byte is the opcode.
  - 0x00–0x02: latch `op_code` = byte[1:0], clear the byte counter, go to RX_A.
  - Any other value: queue a 1-byte NAK response (0x15), go to TX_LOAD.
- **RX_A / RX_B:**
  - Each `rx_valid` shifts left: `op_x <= {op_x[23:0], rx_data}`. A 2-bit byte counter wraps 3→0 and moves RX_A→RX_B→ISSUE.
  - The timeout counter clears on every accepted byte and increments on every other cycle.
  - When the counter reaches `TIMEOUT_CYCLES - 1` with no `rx_valid` that cycle, drop the frame, queue NAK, go to TX_LOAD.
  - If `rx_valid` and expiry occur in the same cycle, the byte wins.
- **ISSUE:**
  - `op_valid` = 1. `op_code`, `op_a`, `op_b` are stable.
  - On `op_valid & op_ready`, go to WAIT_RES.
  - No timeout in this state.
- **WAIT_RES:**
  - On `res_valid` with `res_err` = 0: latch `res_data`, queue 5 bytes: 0x06, then res[31:24], [23:16], [15:8], [7:0].
  - On `res_valid` with `res_err` = 1: queue NAK only.
  - Then go to TX_LOAD.
- **TX_LOAD:** Drive `tx_data` = queued byte[index], pulse `tx_start`, go to TX_WAIT.
- **TX_WAIT:**
  - On `tx_done`: if index < length-1, increment and go to TX_LOAD.
  - Otherwise pulse `done` (ACK response) or `err` (NAK response) and go to IDLE.
- `rx_valid` outside IDLE/RX_A/RX_B is discarded, with no effect on state or operands.
- `res_valid` outside WAIT_RES, and `tx_done` outside TX_WAIT, are ignored.

## Timing
- **Reset:** async assert forces IDLE. All outputs are 0: `tx_start`, `tx_data`, `op_valid`, `op_code`, `op_a`, `op_b`, `busy`, `done`, `err`. Counters are also 0. Reset mid-frame or mid-transmit abandons the command; nothing resumes.
- **Operand to issue:** last B byte `rx_valid` at cycle N gives `op_valid` = 1 at N+1.
- **Handshake:**
  - If `op_ready` = 1 at N+1, `op_valid` = 0 at N+2.
  - With `op_ready` low, `op_valid` stays high and operands are unchanged indefinitely.
- **Result to transmit:** `res_valid` at M gives `tx_start` at M+1 with `tx_data` = 0x06.
- **Byte to byte:** `tx_done` at K gives the next `tx_start` at K+1.
- **Completion:** final `tx_done` at K gives `done`/`err` at K+1 and IDLE at K+1. A new opcode is accepted from K+1.
- **Invalid opcode:** opcode `rx_valid` at cycle P gives `tx_start` with 0x15 at P+1.
- **Timeout:** a NAK `tx_start` is issued `TIMEOUT_CYCLES`+1 cycles after the last accepted byte.
- `tx_start`, `done` and `err` are never high for more than 1 cycle.
- All outputs are registered.

## Test plan
- **Add frame:** send 0x00, 3F800000, 40000000; `op_ready` tied 1.
  - Expect `op_valid` 1 cycle after the last byte, with `op_a`=0x3F800000 and `op_b`=0x40000000.
  - Return `res_data`=0x40400000 → expect TX bytes 06 40 40 00 00 and a single `done` pulse.
- **Invalid opcode:** send 0x07 → expect exactly one TX byte 0x15, an `err` pulse, then IDLE. The next valid frame must complete normally.
- **Timeout** (`TIMEOUT_CYCLES`=100): send 0x02 and 2 bytes, then stop → expect NAK `tx_start` 101 cycles after the last byte. A following full frame must produce correct operands.
- **Backpressure:** hold `op_ready`=0 for 50 cycles during ISSUE and inject `rx_valid` bytes meanwhile.
  - Expect `op_valid` held and operands unchanged throughout.
  - Expect the injected bytes ignored.
  - Expect the handshake to occur on the first `op_ready`=1 cycle.
- **FP error:** `res_valid` with `res_err`=1 → expect a single 0x15 byte and an `err` pulse, with no result bytes.
- **Reset mid-transmit:** assert `reset` after the 2nd `tx_done` of a 5-byte response.
  - Expect all outputs 0 immediately and no further `tx_start`.
  - After release, a fresh frame must work.

Source files
------------

// File: rtl/fp_uart_cmd_sequencer.sv
// fp_uart_cmd_sequencer
//
// Sits between the UART byte link and the floating-point unit. It builds a
// command frame from received bytes (opcode, operand A, operand B, MSB
// first) and issues it to the FP unit. It then waits for the result and
// streams a status byte, plus the result bytes on success, back through
// the transmitter.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   rx_valid, rx_data   one-cycle pulse with a received byte
//   tx_start, tx_data   one-cycle start pulse; byte held until tx_done
//   tx_done             transmitter finished the current byte
//   op_valid, op_ready  FP request handshake (transfer when both high)
//   op_code, op_a, op_b FP request payload (0 add, 1 sub, 2 mul)
//   res_valid           one-cycle pulse: res_data / res_err are valid
//   busy                high whenever the FSM is not IDLE
//   done, err           one-cycle pulse at the end of an ACK / NAK response
//
// Handshake rule: the FP request transfers on a clock edge where
// op_valid and op_ready are both high. While op_valid is high, op_code,
// op_a and op_b do not change.
module fp_uart_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_BITS        = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [1:0]  op_code,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    input  logic        res_err,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [7:0]         ACK     = 8'h06;
    localparam logic [7:0]         NAK     = 8'h15;
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, RX_A, RX_B, ISSUE, WAIT_RES, TX_LOAD, TX_WAIT
    } state_t;

    state_t             state;
    logic [1:0]         byte_cnt;
    logic [TO_BITS-1:0] to_cnt;
    logic [2:0]         tx_idx;    // index of the byte currently being sent
    logic [2:0]         tx_last;   // index of the final byte (0 for NAK, 4 for ACK)
    logic               resp_ack;  // response being sent is an ACK
    logic [31:0]        res_q;

    // Byte idx of the queued response: status byte, then result MSB first.
    function automatic logic [7:0] resp_byte(input logic ack, input logic [2:0] idx,
                                             input logic [31:0] r);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ack ? ACK : NAK;
            3'd1:    b = r[31:24];
            3'd2:    b = r[23:16];
            3'd3:    b = r[15:8];
            3'd4:    b = r[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // The first tx_start is raised on the same edge that enters TX_LOAD, so
    // the pulse is visible during the TX_LOAD cycle itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            to_cnt   <= '0;
            tx_idx   <= 3'd0;
            tx_last  <= 3'd0;
            resp_ack <= 1'b0;
            res_q    <= 32'd0;
            tx_start <= 1'b0;
            tx_data  <= 8'd0;
            op_valid <= 1'b0;
            op_code  <= 2'd0;
            op_a     <= 32'd0;
            op_b     <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        busy <= 1'b1;
                        if (rx_data <= 8'h02) begin
                            op_code  <= rx_data[1:0];
                            byte_cnt <= 2'd0;
                            to_cnt   <= '0;
                            state    <= RX_A;
                        end else begin
                            resp_ack <= 1'b0;
                            tx_last  <= 3'd0;
                            tx_idx   <= 3'd0;
                            tx_data  <= NAK;
                            tx_start <= 1'b1;
                            state    <= TX_LOAD;
                        end
                    end
                end
                RX_A, RX_B: begin
                    // An arriving byte takes priority over timeout expiry.
                    if (rx_valid) begin
                        if (state == RX_A) op_a <= {op_a[23:0], rx_data};
                        else               op_b <= {op_b[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        to_cnt   <= '0;
                        if (byte_cnt == 2'd3) begin
                            if (state == RX_A) begin
                                state <= RX_B;
                            end else begin
                                op_valid <= 1'b1;
                                state    <= ISSUE;
                            end
                        end
                    end else if (to_cnt == TO_LAST) begin
                        resp_ack <= 1'b0;
                        tx_last  <= 3'd0;
                        tx_idx   <= 3'd0;
                        tx_data  <= NAK;
                        tx_start <= 1'b1;
                        state    <= TX_LOAD;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        tx_idx   <= 3'd0;
                        tx_start <= 1'b1;
                        state    <= TX_LOAD;
                        if (!res_err) begin
                            res_q    <= res_data;
                            resp_ack <= 1'b1;
                            tx_last  <= 3'd4;
                            tx_data  <= ACK;
                        end else begin
                            resp_ack <= 1'b0;
                            tx_last  <= 3'd0;
                            tx_data  <= NAK;
                        end
                    end
                end
                TX_LOAD: begin
                    state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done) begin
                        if (tx_idx != tx_last) begin
                            tx_idx   <= tx_idx + 3'd1;
                            tx_data  <= resp_byte(resp_ack, tx_idx + 3'd1, res_q);
                            tx_start <= 1'b1;
                            state    <= TX_LOAD;
                        end else begin
                            done  <= resp_ack;
                            err   <= ~resp_ack;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_uart_cmd_sequencer.sv
// Testbench for fp_uart_cmd_sequencer. Expected TX bytes, completions and
// FP requests are queued as stimulus is issued. Monitor processes pop them
// and compare whenever the DUT presents tx_start, done/err or an FP handshake.
module tb_fp_uart_cmd_sequencer;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [1:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = 32'h0;
    logic        res_err = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];     // expected transmitted bytes, in order
    logic        exp_end[$];   // expected completion: 1 = done, 0 = err
    logic [65:0] exp_op[$];    // expected FP requests {code, a, b}

    int          force_mode = 0;   // 0 random result, 1 ok with force_data, 2 FP error
    logic [31:0] force_data = 32'h0;
    int          tx_done_cnt = 0;
    bit          rand_ready = 1'b0;

    always #5 clk = ~clk;

    fp_uart_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .TO_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference model of a response: ACK + result bytes MSB first, or NAK alone.
    task automatic push_response(input bit ok, input logic [31:0] r);
        if (ok) begin
            exp_q.push_back(8'h06);
            for (int i = 3; i >= 0; i--) exp_q.push_back(8'((r >> (8 * i)) & 32'hFF));
            exp_end.push_back(1'b1);
        end else begin
            exp_q.push_back(8'h15);
            exp_end.push_back(1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] opc, input logic [31:0] a,
                              input logic [31:0] b, input int maxgap);
        if (opc <= 8'h02) begin
            exp_op.push_back({opc[1:0], a, b});
            send_byte(opc, int'($urandom_range(0, maxgap)));
            for (int i = 3; i >= 0; i--) send_byte(8'(a >> (8 * i)), int'($urandom_range(0, maxgap)));
            for (int i = 3; i >= 0; i--) send_byte(8'(b >> (8 * i)), int'($urandom_range(0, maxgap)));
        end else begin
            push_response(1'b0, 32'h0);
            send_byte(opc, int'($urandom_range(0, maxgap)));
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            if (rand_ready) op_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check({name, "_idle"}, busy, 1'b0);
        #2;
        check({name, "_drained"}, exp_q.size() + exp_end.size() + exp_op.size(), 0);
    endtask

    // Transmitter model plus TX / completion monitor.
    logic [7:0] cur_byte = 8'h00;
    int         tx_cnt = 0;
    bit         had_done = 1'b0, prev_ts = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
    logic       e_end;

    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            tx_done = 1'b0; tx_cnt = 0; had_done = 1'b0;
            prev_ts = 1'b0; prev_done = 1'b0; prev_err = 1'b0;
        end else begin
            if (had_done) begin
                if (exp_q.size() > 0) check("next_byte_latency", tx_start, 1'b1);
                else                  check("completion_latency", done | err, 1'b1);
            end
            had_done = 1'b0;
            if (tx_start) begin
                check("tx_start_pulse", prev_ts, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tx_start: tx_data=%0h, no byte expected", tx_data);
                end else begin
                    cur_byte = exp_q.pop_front();
                    check("tx_byte", tx_data, cur_byte);
                end
            end
            if (done || err) begin
                check("done_err_pulse", (prev_done & done) | (prev_err & err) | (done & err), 1'b0);
                if (exp_end.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_completion: done=%0b err=%0b, none expected", done, err);
                end else begin
                    e_end = exp_end.pop_front();
                    check("completion_kind", {done, err}, e_end ? 2'b10 : 2'b01);
                end
            end
            prev_ts = tx_start; prev_done = done; prev_err = err;
            if (tx_done) begin
                tx_done = 1'b0;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_done = 1'b1;
                    tx_done_cnt++;
                    had_done = 1'b1;
                    check("tx_data_hold", tx_data, cur_byte);
                end
            end
            if (tx_start) tx_cnt = int'($urandom_range(1, 4));
        end
    end

    // FP unit model: checks each accepted request, then returns a result.
    int          res_cnt = 0;
    bit          res_fire_prev = 1'b0;
    bit          ok;
    logic [31:0] d;
    logic [65:0] e_op;

    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            res_valid = 1'b0; res_err = 1'b0; res_cnt = 0; res_fire_prev = 1'b0;
        end else begin
            if (res_fire_prev) check("result_to_tx_start", tx_start, 1'b1);
            res_fire_prev = 1'b0;
            res_valid = 1'b0;
            res_err = 1'b0;
            if (res_cnt > 0) begin
                res_cnt--;
                if (res_cnt == 0) begin
                    case (force_mode)
                        1:       begin ok = 1'b1; d = force_data; end
                        2:       begin ok = 1'b0; d = $urandom; end
                        default: begin ok = ($urandom_range(0, 3) != 0); d = $urandom; end
                    endcase
                    res_valid = 1'b1;
                    res_data = d;
                    res_err = ~ok;
                    push_response(ok, d);
                    res_fire_prev = 1'b1;
                end
            end
            if (op_valid && op_ready) begin
                if (exp_op.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_request: op_code=%0d a=%0h b=%0h", op_code, op_a, op_b);
                end else begin
                    e_op = exp_op.pop_front();
                    check("op_code", op_code, e_op[65:64]);
                    check("op_a", op_a, e_op[63:32]);
                    check("op_b", op_b, e_op[31:0]);
                end
                res_cnt = int'($urandom_range(1, 5));
            end
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int          off;
        int          n;
        int          hold_bad;
        int          starts;
        int          base;
        logic [31:0] a, b;
        logic [7:0]  opc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_op_valid", op_valid, 1'b0);
        check("rst_op_fields", {op_code, op_a, op_b}, 66'h0);
        check("rst_busy_done_err", {busy, done, err}, 3'b000);
        reset = 1'b0;

        // Add frame
        op_ready = 1'b1;
        force_mode = 1;
        force_data = 32'h40400000;
        send_frame(8'h00, 32'h3F800000, 32'h40000000, 0);
        check("issue_latency", op_valid, 1'b1);
        check("add_op_a", op_a, 32'h3F800000);
        check("add_op_b", op_b, 32'h40000000);
        @(negedge clk);
        check("handshake_drop", op_valid, 1'b0);
        wait_idle("add");

        // Invalid opcode, then a normal frame
        force_mode = 0;
        send_frame(8'h07, 32'h0, 32'h0, 0);
        check("nak_latency", {tx_start, tx_data}, {1'b1, 8'h15});
        wait_idle("bad_opcode");
        send_frame(8'h01, $urandom, $urandom, 1);
        wait_idle("after_bad");

        // Timeout after opcode and two operand bytes
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        check("busy_mid_frame", busy, 1'b1);
        push_response(1'b0, 32'h0);
        off = 1;
        while (!tx_start && off < 300) begin
            @(negedge clk);
            off++;
        end
        check("timeout_latency", off, TO + 1);
        wait_idle("timeout");
        send_frame(8'h02, 32'hC0490FDB, 32'h3E99999A, 0);
        wait_idle("after_timeout");

        // A byte arriving in the expiry cycle is accepted
        a = $urandom; b = $urandom;
        exp_op.push_back({2'd1, a, b});
        send_byte(8'h01, 0);
        for (int i = 3; i >= 0; i--) send_byte(8'(a >> (8 * i)), 0);
        send_byte(b[31:24], TO - 2);
        for (int i = 2; i >= 0; i--) send_byte(8'(b >> (8 * i)), 0);
        wait_idle("expiry_edge");

        // Backpressure with injected bytes during ISSUE
        op_ready = 1'b0;
        a = $urandom; b = $urandom;
        send_frame(8'h02, a, b, 0);
        check("bp_issue", op_valid, 1'b1);
        hold_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (op_valid !== 1'b1 || op_code !== 2'd2 || op_a !== a || op_b !== b || busy !== 1'b1)
                hold_bad++;
            rx_valid = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom);
        end
        @(negedge clk);
        if (op_valid !== 1'b1 || op_code !== 2'd2 || op_a !== a || op_b !== b) hold_bad++;
        rx_valid = 1'b0;
        check("bp_hold_cycles_bad", hold_bad, 0);
        op_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake", op_valid, 1'b0);
        wait_idle("backpressure");

        // FP exception
        force_mode = 2;
        send_frame(8'h00, $urandom, $urandom, 0);
        wait_idle("fp_error");

        // Reset mid-transmit after the second tx_done
        force_mode = 1;
        force_data = $urandom;
        base = tx_done_cnt;
        send_frame(8'h02, $urandom, $urandom, 0);
        n = 0;
        while (tx_done_cnt < base + 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_2nd_done", tx_done_cnt >= base + 2, 1'b1);
        reset = 1'b1;
        #1;
        check("midrst_outputs", {tx_start, tx_data, op_valid, op_code, op_a, op_b, busy, done, err}, 81'h0);
        exp_q.delete();
        exp_end.delete();
        exp_op.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        check("no_tx_after_reset", starts, 0);
        force_mode = 0;
        send_frame(8'h01, $urandom, $urandom, 0);
        wait_idle("after_reset");

        // Randomized frames
        rand_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 4) == 0) opc = 8'($urandom_range(3, 255));
            else                           opc = 8'($urandom_range(0, 2));
            send_frame(opc, $urandom, $urandom, 3);
            wait_idle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
